ad9783_spi_responder: RTL and testbench
=======================================

# ad9783_spi_responder

SPI target that models the AD9783 serial control port: it decodes the 16-bit frames the DAC controller issues (write `{0, 2'b00, addr[4:0], data[7:0]}`, read `{1, 2'b00, addr[4:0], 8'h00}`), holds a 32 x 8 register file, and returns register contents on SDO during reads. It oversamples the SPI pins on the system clock. It serves as the DAC-side counterpart in simulation benches and as an SPI register target for loopback on the board.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizers on `spi_scs_in`, `spi_sck_in` and `spi_sdi_in`; legal range 2-3.
- `SMP_DLY_INIT`, default 8'h00: reset value of register 0x05.

Ports:
- `clk_in`, in, 1: system clock, 100 MHz nominal. The design has one clock.
- `rst_in`, in, 1: reset; asynchronous and active-high.
- `spi_scs_in`, in, 1: chip select, active low.
- `spi_sck_in`, in, 1: SPI clock; idles low.
- `spi_sdi_in`, in, 1: serial data from the master, MSB first.
- `spi_sdo_out`, out, 1: serial read data to the master.
- `wr_strobe_out`, out, 1: one-cycle pulse when a register write commits.
- `wr_addr_out`, out, 5: address of the last committed write.
- `wr_data_out`, out, 8: data of the last committed write.
- `smp_dly_out`, out, 8: live contents of register 0x05.
- `frame_err_out`, out, 1: one-cycle pulse when a frame is aborted.

## Operation
- SPI mode: CPOL=0, CPHA=0.
  - The target samples SDI on rising SCK.
  - The target changes SDO after falling SCK.
- All SPI inputs pass through `SYNC_STAGES` synchronizer flops.
- Edges of the synchronized SCK are detected against a further registered copy.
- SDI is delayed by the same depth, so the sampled bit aligns with the detected rising edge.
- Shift register: 16 bits, MSB first.
- Bit counter: 5 bits.
- State machine:
  - IDLE: SCS high; counter cleared; SDO=0. Go to INSTR when the synchronized SCS is low.
  - INSTR: shift one bit per rising edge. After the 8th bit, latch rw = bit15 and addr = bits 12:8, then go to DATA. Bits 14:13 are ignored; every frame is treated as a single byte.
  - DATA:
    - Read (rw=1): on the first falling edge after entering DATA, load the SDO shifter with reg[addr]. Drive its bit7, then shift left on each later falling edge.
    - Write (rw=0): shift one SDI bit per rising edge.
    - After the 16th rising edge, go to DONE.
    - For a write, the register update happens in the same clock in which the 16th rising edge is detected (see Timing).
  - DONE: ignore all further SCK edges; SDO=0. Go to IDLE when SCS goes high.
  - Abort: SCS high in INSTR or DATA (fewer than 16 bits received) does the following:
    - pulse `frame_err_out`;
    - perform no write;
    - set SDO=0;
    - go to IDLE.
- SDO is 0 at all times except during the DATA phase of a read.
- Reads have no side effects.

## Timing
- Reset values:
  - all registers 8'h00, except reg 0x05 = `SMP_DLY_INIT`;
  - `spi_sdo_out`=0, `wr_strobe_out`=0, `frame_err_out`=0;
  - `wr_addr_out`=0, `wr_data_out`=0;
  - `smp_dly_out`=`SMP_DLY_INIT`;
  - state IDLE; synchronizers cleared to SCS=1, SCK=0.
- Reset in mid-frame: the partial frame is discarded. After release, if SCS is still low, the state machine waits in DONE until SCS goes high, so it never decodes a partial frame.
- Write commit: in the same clock as the 16th rising-edge detect, the following happen together:
  - reg[addr] updates;
  - `wr_addr_out` and `wr_data_out` load;
  - `wr_strobe_out` is high for exactly 1 cycle;
  - `smp_dly_out` reflects the new value on the next cycle if addr=0x05.
- Pin-to-action latency: a rising or falling SCK edge at the pin is acted on `SYNC_STAGES`+1 clk_in cycles later. `spi_sdo_out` is registered, adding 1 more cycle.
- Minimum SCK high/low time: `SYNC_STAGES`+3 clk_in cycles. With the nominal 50 ns half-period (5 cycles) and `SYNC_STAGES`=2, SDO settles at least 1 cycle before the next rising edge at the master.
- Minimum SCS-high time between frames: `SYNC_STAGES`+2 cycles.
- If the SCS rise and the final rising SCK edge are detected in the same cycle, the frame completes; no abort.

## Test plan
- Reset, then read 0x05 (frame 16'h8500) -> SDO returns 8'h00 (default `SMP_DLY_INIT`); `smp_dly_out`=8'h00; no strobe.
- Write 16'h0A5C, then read 16'h8A00 -> one `wr_strobe_out` pulse with `wr_addr_out`=5'h0A and `wr_data_out`=8'h5C; the read returns 8'h5C MSB-first with 0 on SDO during the instruction byte.
- Write 16'h0513 -> `smp_dly_out`=8'h13. Then write 16'h1F01 and 16'h0002, and read both back -> 8'h01 and 8'h02; `smp_dly_out` stays 8'h13.
- Raise SCS after 11 bits of 16'h0377 -> `frame_err_out` pulses once; reg 0x03 is unchanged; the next full frame decodes correctly.
- Send 20 SCK pulses in one frame with write 16'h0444 -> a single commit of 8'h44 to 0x04; the extra bits are ignored.
- Assert `rst_in` mid-write with SCS held low, release, then complete the clocks -> no write; the next frame after SCS goes high decodes normally; all outputs hold their reset values throughout.

Source files
------------

// File: rtl/ad9783_spi_responder.sv
// ad9783_spi_responder
//   Serial-port target modelling the AD9783 control interface. Decodes 16-bit
//   SPI frames (write {0,2'b00,addr[4:0],data[7:0]}, read {1,2'b00,addr[4:0],8'h00}),
//   keeps a 32 x 8 register file and returns register contents on SDO for reads.
//   The SPI pins are oversampled on clk_in (CPOL=0, CPHA=0).
//
// Ports
//   clk_in         system clock
//   rst_in         asynchronous active-high reset
//   spi_scs_in     chip select, active low
//   spi_sck_in     SPI clock, idles low
//   spi_sdi_in     serial data in, MSB first
//   spi_sdo_out    serial read data out (0 except in the data byte of a read)
//   wr_strobe_out  one-cycle pulse when a register write commits
//   wr_addr_out    address of the last committed write
//   wr_data_out    data of the last committed write
//   smp_dly_out    live contents of register 0x05
//   frame_err_out  one-cycle pulse when a frame is aborted by SCS rising early
module ad9783_spi_responder #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [7:0]  SMP_DLY_INIT = 8'h00
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       spi_scs_in,
  input  logic       spi_sck_in,
  input  logic       spi_sdi_in,
  output logic       spi_sdo_out,
  output logic       wr_strobe_out,
  output logic [4:0] wr_addr_out,
  output logic [7:0] wr_data_out,
  output logic [7:0] smp_dly_out,
  output logic       frame_err_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INSTR = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [SYNC_STAGES-1:0] scs_sync_q, scs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sck_dly_q, sck_dly_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   armed_q, armed_d;

  logic [1:0]  state_q, state_d;
  // Holds the bits received so far; together with the incoming bit it forms
  // the full 16-bit frame at the 16th rising edge.
  logic [14:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  sdo_sh_q, sdo_sh_d;
  logic        sdo_ld_q, sdo_ld_d;
  logic        sdo_q, sdo_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  regs_q [32];
  logic [7:0]  regs_d [32];

  logic scs_s, sck_s, sdi_s, sck_rise, sck_fall, sync_vld;

  always_comb begin
    scs_s    = scs_sync_q[SYNC_STAGES-1];
    sck_s    = sck_sync_q[SYNC_STAGES-1];
    sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    sck_rise = sck_s & ~sck_dly_q;
    sck_fall = ~sck_s & sck_dly_q;
    // Synchronizer outputs are only trusted once the reset fill values have
    // been flushed by real pin samples.
    sync_vld = fill_q[SYNC_STAGES-1];
  end

  always_comb begin
    scs_sync_d = {scs_sync_q[SYNC_STAGES-2:0], spi_scs_in};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_in};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_in};
    sck_dly_d  = sck_s;
    fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
    // A frame may only start after SCS has been seen high; this keeps a
    // frame interrupted by reset from being decoded from its middle.
    armed_d    = armed_q | (sync_vld & scs_s);

    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    sdo_sh_d    = sdo_sh_q;
    sdo_ld_d    = sdo_ld_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    regs_d      = regs_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = 5'd0;
        sdo_sh_d = 8'h00;
        sdo_ld_d = 1'b0;
        if (sync_vld && !scs_s) begin
          state_d = armed_q ? ST_INSTR : ST_DONE;
        end
      end
      ST_INSTR: begin
        if (sck_rise) begin
          shift_d = {shift_q[13:0], sdi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            rw_d    = shift_q[6];
            addr_d  = {shift_q[3:0], sdi_s};
            state_d = ST_DATA;
          end
        end else if (scs_s) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_DATA: begin
        // A final rising edge seen together with SCS high still completes.
        if (sck_rise) begin
          shift_d = {shift_q[13:0], sdi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_d = ST_DONE;
            // shift_q[14] is frame bit 15, the read/write flag.
            if (!shift_q[14]) begin
              regs_d[addr_q] = {shift_q[6:0], sdi_s};
              wr_strobe_d    = 1'b1;
              wr_addr_d      = addr_q;
              wr_data_d      = {shift_q[6:0], sdi_s};
            end
          end
        end else if (scs_s) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (sck_fall && rw_q) begin
          if (!sdo_ld_q) begin
            sdo_sh_d = regs_q[addr_q];
            sdo_ld_d = 1'b1;
          end else begin
            sdo_sh_d = {sdo_sh_q[6:0], 1'b0};
          end
        end
      end
      default: begin
        if (scs_s) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    sdo_d = (state_q == ST_DATA && rw_q) ? sdo_sh_q[7] : 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scs_sync_q  <= '1;
      sck_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sck_dly_q   <= 1'b0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= 5'd0;
      rw_q        <= 1'b0;
      addr_q      <= 5'd0;
      sdo_sh_q    <= 8'h00;
      sdo_ld_q    <= 1'b0;
      sdo_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 5) ? SMP_DLY_INIT : 8'h00;
      end
    end else begin
      scs_sync_q  <= scs_sync_d;
      sck_sync_q  <= sck_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sck_dly_q   <= sck_dly_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      sdo_sh_q    <= sdo_sh_d;
      sdo_ld_q    <= sdo_ld_d;
      sdo_q       <= sdo_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign spi_sdo_out   = sdo_q;
  assign wr_strobe_out = wr_strobe_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign smp_dly_out   = regs_q[5];
  assign frame_err_out = frame_err_q;

endmodule

// File: tb/tb_ad9783_spi_responder.sv
// tb_ad9783_spi_responder
//   Directed bench for ad9783_spi_responder: an SPI master (mode 0, 5-cycle
//   half period) issues frames, and each scenario task compares outputs
//   against hand-computed values.
module tb_ad9783_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_scs;
  logic       spi_sck;
  logic       spi_sdi;
  logic       spi_sdo;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] smp_dly;
  logic       frame_err;

  int n_pass  = 0;
  int n_total = 0;

  int         strobe_cnt = 0;
  int         err_cnt    = 0;
  logic [4:0] cap_addr   = 5'd0;
  logic [7:0] cap_data   = 8'h00;

  logic [7:0] rd_byte;
  int         instr_ones;
  int         tail_ones;

  always #5 clk = ~clk;

  ad9783_spi_responder #(
    .SYNC_STAGES (2),
    .SMP_DLY_INIT(8'h00)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .spi_scs_in   (spi_scs),
    .spi_sck_in   (spi_sck),
    .spi_sdi_in   (spi_sdi),
    .spi_sdo_out  (spi_sdo),
    .wr_strobe_out(wr_strobe),
    .wr_addr_out  (wr_addr),
    .wr_data_out  (wr_data),
    .smp_dly_out  (smp_dly),
    .frame_err_out(frame_err)
  );

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      cap_addr   = wr_addr;
      cap_data   = wr_data;
    end
    if (frame_err === 1'b1) begin
      err_cnt = err_cnt + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scs_low();
    instr_ones = 0;
    tail_ones  = 0;
    rd_byte    = 8'h00;
    spi_scs    = 1'b0;
    wait_cyc(5);
  endtask

  task automatic scs_high();
    wait_cyc(5);
    spi_scs = 1'b1;
    wait_cyc(12);
  endtask

  // Master side: SDI set while SCK low, SDO sampled just before each rising edge.
  task automatic clock_bits(input logic [15:0] frame, input int first, input int last);
    for (int i = first; i < last; i++) begin
      spi_sdi = (i < 16) ? frame[15-i] : 1'b0;
      wait_cyc(5);
      if (i < 8)       instr_ones = instr_ones + int'(spi_sdo);
      else if (i < 16) rd_byte[15-i] = spi_sdo;
      else             tail_ones = tail_ones + int'(spi_sdo);
      spi_sck = 1'b1;
      wait_cyc(5);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [15:0] frame, input int npulses);
    scs_low();
    clock_bits(frame, 0, npulses);
    scs_high();
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_scs = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    n_total++; if (spi_sdo !== 1'b0)   $display("FAIL reset_sdo got %b want 0", spi_sdo); else n_pass++;
    n_total++; if (wr_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", wr_strobe); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else n_pass++;
    n_total++; if (wr_addr !== 5'h00)  $display("FAIL reset_wr_addr got %h want 00", wr_addr); else n_pass++;
    n_total++; if (wr_data !== 8'h00)  $display("FAIL reset_wr_data got %h want 00", wr_data); else n_pass++;
    n_total++; if (smp_dly !== 8'h00)  $display("FAIL reset_smp_dly got %h want 00", smp_dly); else n_pass++;
    wait_cyc(10);
  endtask

  task automatic test_read_default();
    xfer(16'h8500, 16);
    n_total++; if (rd_byte !== 8'h00)  $display("FAIL rd_default_05 got %h want 00", rd_byte); else n_pass++;
    n_total++; if (smp_dly !== 8'h00)  $display("FAIL smp_dly_default got %h want 00", smp_dly); else n_pass++;
    n_total++; if (strobe_cnt !== 0)   $display("FAIL rd_default_strobe got %0d want 0", strobe_cnt); else n_pass++;
  endtask

  task automatic test_write_read();
    int s0;
    s0 = strobe_cnt;
    xfer(16'h0A5C, 16);
    n_total++; if (strobe_cnt - s0 !== 1) $display("FAIL wr_0a_strobes got %0d want 1", strobe_cnt - s0); else n_pass++;
    n_total++; if (cap_addr !== 5'h0A)    $display("FAIL wr_0a_addr got %h want 0a", cap_addr); else n_pass++;
    n_total++; if (cap_data !== 8'h5C)    $display("FAIL wr_0a_data got %h want 5c", cap_data); else n_pass++;
    n_total++; if (wr_data !== 8'h5C)     $display("FAIL wr_0a_data_hold got %h want 5c", wr_data); else n_pass++;
    n_total++; if (rd_byte !== 8'h00 || instr_ones !== 0)
      $display("FAIL wr_0a_sdo_quiet got data %h instr_ones %0d want 00 and 0", rd_byte, instr_ones); else n_pass++;
    xfer(16'h8A00, 16);
    n_total++; if (rd_byte !== 8'h5C)     $display("FAIL rd_0a got %h want 5c", rd_byte); else n_pass++;
    n_total++; if (instr_ones !== 0)      $display("FAIL rd_0a_instr_sdo got %0d ones want 0", instr_ones); else n_pass++;
    n_total++; if (strobe_cnt - s0 !== 1) $display("FAIL rd_0a_no_strobe got %0d want 1", strobe_cnt - s0); else n_pass++;
  endtask

  task automatic test_smp_dly();
    xfer(16'h0513, 16);
    n_total++; if (smp_dly !== 8'h13) $display("FAIL smp_dly_wr got %h want 13", smp_dly); else n_pass++;
    xfer(16'h1F01, 16);
    xfer(16'h0002, 16);
    xfer(16'h9F00, 16);
    n_total++; if (rd_byte !== 8'h01) $display("FAIL rd_1f got %h want 01", rd_byte); else n_pass++;
    xfer(16'h8000, 16);
    n_total++; if (rd_byte !== 8'h02) $display("FAIL rd_00 got %h want 02", rd_byte); else n_pass++;
    n_total++; if (smp_dly !== 8'h13) $display("FAIL smp_dly_kept got %h want 13", smp_dly); else n_pass++;
  endtask

  task automatic test_abort();
    int e0;
    int s0;
    e0 = err_cnt;
    s0 = strobe_cnt;
    xfer(16'h0377, 11);
    n_total++; if (err_cnt - e0 !== 1)    $display("FAIL abort_err got %0d want 1", err_cnt - e0); else n_pass++;
    n_total++; if (strobe_cnt - s0 !== 0) $display("FAIL abort_no_write got %0d want 0", strobe_cnt - s0); else n_pass++;
    n_total++; if (spi_sdo !== 1'b0)      $display("FAIL abort_sdo got %b want 0", spi_sdo); else n_pass++;
    xfer(16'h8300, 16);
    n_total++; if (rd_byte !== 8'h00)     $display("FAIL abort_rd_03 got %h want 00", rd_byte); else n_pass++;
    xfer(16'h8A00, 16);
    n_total++; if (rd_byte !== 8'h5C)     $display("FAIL post_abort_rd_0a got %h want 5c", rd_byte); else n_pass++;
    n_total++; if (err_cnt - e0 !== 1)    $display("FAIL post_abort_err got %0d want 1", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_extra_pulses();
    int s0;
    int e0;
    s0 = strobe_cnt;
    e0 = err_cnt;
    xfer(16'h0444, 20);
    n_total++; if (strobe_cnt - s0 !== 1) $display("FAIL extra_strobes got %0d want 1", strobe_cnt - s0); else n_pass++;
    n_total++; if (cap_addr !== 5'h04 || cap_data !== 8'h44)
      $display("FAIL extra_commit got %h/%h want 04/44", cap_addr, cap_data); else n_pass++;
    n_total++; if (tail_ones !== 0)       $display("FAIL extra_tail_sdo got %0d ones want 0", tail_ones); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0)    $display("FAIL extra_err got %0d want 0", err_cnt - e0); else n_pass++;
    xfer(16'h8400, 16);
    n_total++; if (rd_byte !== 8'h44)     $display("FAIL rd_04 got %h want 44", rd_byte); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s0;
    int e0;
    s0 = strobe_cnt;
    e0 = err_cnt;
    scs_low();
    clock_bits(16'h0666, 0, 6);
    rst = 1'b1;
    wait_cyc(2);
    n_total++; if (smp_dly !== 8'h00 || wr_addr !== 5'h00 || wr_data !== 8'h00 || spi_sdo !== 1'b0)
      $display("FAIL mid_rst_outputs got smp %h addr %h data %h sdo %b want 00 00 00 0",
               smp_dly, wr_addr, wr_data, spi_sdo); else n_pass++;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(5);
    clock_bits(16'h0666, 6, 16);
    scs_high();
    n_total++; if (strobe_cnt - s0 !== 0) $display("FAIL mid_rst_no_write got %0d want 0", strobe_cnt - s0); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0)    $display("FAIL mid_rst_no_err got %0d want 0", err_cnt - e0); else n_pass++;
    n_total++; if (rd_byte !== 8'h00 || instr_ones !== 0)
      $display("FAIL mid_rst_sdo got %h/%0d want 00/0", rd_byte, instr_ones); else n_pass++;
    n_total++; if (smp_dly !== 8'h00 || wr_addr !== 5'h00 || wr_data !== 8'h00)
      $display("FAIL mid_rst_after got smp %h addr %h data %h want 00 00 00", smp_dly, wr_addr, wr_data); else n_pass++;
    xfer(16'h8600, 16);
    n_total++; if (rd_byte !== 8'h00) $display("FAIL mid_rst_rd_06 got %h want 00", rd_byte); else n_pass++;
    xfer(16'h8A00, 16);
    n_total++; if (rd_byte !== 8'h00) $display("FAIL mid_rst_rd_0a_cleared got %h want 00", rd_byte); else n_pass++;
    xfer(16'h0666, 16);
    n_total++; if (strobe_cnt - s0 !== 1 || cap_data !== 8'h66)
      $display("FAIL post_rst_write got %0d strobes data %h want 1 and 66", strobe_cnt - s0, cap_data); else n_pass++;
    xfer(16'h8600, 16);
    n_total++; if (rd_byte !== 8'h66) $display("FAIL post_rst_rd_06 got %h want 66", rd_byte); else n_pass++;
  endtask

  initial begin
    rst     = 1'b1;
    spi_scs = 1'b1;
    spi_sck = 1'b0;
    spi_sdi = 1'b0;
    test_reset();
    test_read_default();
    test_write_read();
    test_smp_dly();
    test_abort();
    test_extra_pulses();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
